// File: rtl/fpdiv_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpdiv_if : Start/Done handshake, operands and result flags for     |
// |            fpdiv. FPDIV_DZF_EN adds the divide-by-zero flag.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface fpdiv_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [31:0] p;
  logic        uf;
  logic        of;
  logic        nanf;
  logic        inff;
  logic        dnf;
  logic        zf;
`ifdef FPDIV_DZF_EN
  logic        dzf;
`endif

  modport master (
    output start, a, b,
`ifdef FPDIV_DZF_EN
    input  dzf,
`endif
    input  done, p, uf, of, nanf, inff, dnf, zf
  );

  modport slave (
    input  start, a, b,
`ifdef FPDIV_DZF_EN
    output dzf,
`endif
    output done, p, uf, of, nanf, inff, dnf, zf
  );
endinterface
`default_nettype wire

// File: rtl/fpdiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpdiv    : multi-cycle IEEE-754 single-precision divider, restoring |
// |            mantissa division with round-to-nearest-even.           |
// |            FPDIV_DZF_EN enables the divide-by-zero flag output.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fpdiv (
  input  wire logic clk,
  input  wire logic rst,
  fpdiv_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [22:0]        ma_q, ma_d, mb_q, mb_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  e_q, e_d;
  logic [24:0]        r_q, r_d;
  logic [23:0]        dv_q, dv_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [22:0]        frac_q, frac_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [31:0]        p_q, p_d;
  logic               uf_q, uf_d, of_q, of_d, nanf_q, nanf_d;
  logic               inff_q, inff_d, dnf_q, dnf_d, zf_q, zf_d;
`ifdef FPDIV_DZF_EN
  logic               dzf_q, dzf_d;
`endif

  // Operand classification; exponent 0 counts as zero, so denormals flush.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_dn;
  assign a_zero = (ea_q == 8'd0);
  assign b_zero = (eb_q == 8'd0);
  assign a_inf  = (&ea_q) && (ma_q == 23'd0);
  assign b_inf  = (&eb_q) && (mb_q == 23'd0);
  assign a_nan  = (&ea_q) && (ma_q != 23'd0);
  assign b_nan  = (&eb_q) && (mb_q != 23'd0);
  assign any_dn = (a_zero && (ma_q != 23'd0)) || (b_zero && (mb_q != 23'd0));

  // Result-write staging: every write replaces P and the whole flag set.
  logic               wr;
  logic [31:0]        p_new;
  logic               f_uf, f_of, f_nan, f_inf, f_dn, f_z, f_dz;
  logic               r_ge, inc, carry;
  logic [24:0]        diff;
  logic [22:0]        fr;
  logic signed [9:0]  e_r;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sign_d   = sign_q;
    e_d      = e_q;
    r_d      = r_q;
    dv_d     = dv_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    p_new    = 32'd0;
    f_uf     = 1'b0;
    f_of     = 1'b0;
    f_nan    = 1'b0;
    f_inf    = 1'b0;
    f_dn     = 1'b0;
    f_z      = 1'b0;
    f_dz     = 1'b0;
    r_ge     = (r_q >= {1'b0, dv_q});
    diff     = r_q - {1'b0, dv_q};
    inc      = guard_q & (sticky_q | frac_q[0]);
    {carry, fr} = {1'b0, frac_q} + {23'd0, inc};
    e_r      = carry ? (e_q + 10'sd1) : e_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a[31];
          ea_d    = bus.a[30:23];
          ma_d    = bus.a[22:0];
          sb_d    = bus.b[31];
          eb_d    = bus.b[30:23];
          mb_d    = bus.b[22:0];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        sign_d  = sa_q ^ sb_q;
        e_d     = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        r_d     = {2'b01, ma_q};
        dv_d    = {1'b1, mb_q};
        quo_d   = 26'd0;
        cnt_d   = 5'd0;
        state_d = S_DIV;
        f_dn    = any_dn;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          wr    = 1'b1;
          p_new = 32'h7FC0_0000;
          f_nan = 1'b1;
        end else if (a_inf || b_zero) begin
          wr    = 1'b1;
          p_new = {sa_q ^ sb_q, 8'hFF, 23'd0};
          f_inf = 1'b1;
          f_dz  = b_zero && !a_inf;
        end else if (a_zero || b_inf) begin
          wr    = 1'b1;
          p_new = {sa_q ^ sb_q, 31'd0};
          f_z   = 1'b1;
        end
        if (wr) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        quo_d = {quo_q[24:0], r_ge};
        r_d   = (r_ge ? diff : r_q) << 1;
        if (cnt_q == 5'd25) begin
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_NORM: begin
        if (quo_q[25]) begin
          frac_d   = quo_q[24:2];
          guard_d  = quo_q[1];
          sticky_d = quo_q[0] | (r_q != 25'd0);
        end else begin
          frac_d   = quo_q[23:1];
          guard_d  = quo_q[0];
          sticky_d = (r_q != 25'd0);
          e_d      = e_q - 10'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        wr = 1'b1;
        if (e_r >= 10'sd255) begin
          p_new = {sign_q, 8'hFF, 23'd0};
          f_of  = 1'b1;
          f_inf = 1'b1;
        end else if (e_r <= 10'sd0) begin
          p_new = {sign_q, 31'd0};
          f_uf  = 1'b1;
          f_z   = 1'b1;
        end else begin
          p_new = {sign_q, e_r[7:0], fr};
        end
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    p_d    = wr ? p_new : p_q;
    uf_d   = wr ? f_uf  : uf_q;
    of_d   = wr ? f_of  : of_q;
    nanf_d = wr ? f_nan : nanf_q;
    inff_d = wr ? f_inf : inff_q;
    dnf_d  = wr ? f_dn  : dnf_q;
    zf_d   = wr ? f_z   : zf_q;
`ifdef FPDIV_DZF_EN
    dzf_d  = wr ? f_dz  : dzf_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ea_q     <= 8'd0;
      eb_q     <= 8'd0;
      ma_q     <= 23'd0;
      mb_q     <= 23'd0;
      sign_q   <= 1'b0;
      e_q      <= 10'sd0;
      r_q      <= 25'd0;
      dv_q     <= 24'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      frac_q   <= 23'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= 32'd0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
      nanf_q   <= 1'b0;
      inff_q   <= 1'b0;
      dnf_q    <= 1'b0;
      zf_q     <= 1'b0;
`ifdef FPDIV_DZF_EN
      dzf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      r_q      <= r_d;
      dv_q     <= dv_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      p_q      <= p_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
      nanf_q   <= nanf_d;
      inff_q   <= inff_d;
      dnf_q    <= dnf_d;
      zf_q     <= zf_d;
`ifdef FPDIV_DZF_EN
      dzf_q    <= dzf_d;
`endif
    end
  end

  assign bus.done = done_q;
  assign bus.p    = p_q;
  assign bus.uf   = uf_q;
  assign bus.of   = of_q;
  assign bus.nanf = nanf_q;
  assign bus.inff = inff_q;
  assign bus.dnf  = dnf_q;
  assign bus.zf   = zf_q;
`ifdef FPDIV_DZF_EN
  assign bus.dzf  = dzf_q;
`endif

endmodule
`default_nettype wire
